// File: rtl/atanh_approx_4bit_stream.sv
// atanh_approx_4bit_stream: streaming inverse-tanh lookup.
// Input is an unsigned Q0.4 tanh-domain code. Output is an unsigned Q2.2
// atanh code. The datapath is a two-stage elastic valid/ready pipeline with
// frame delimiting. Sample and frame handshake counters are included.
module atanh_approx_4bit_stream #(
  parameter int CNT_W = 16,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       In,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       Out1,
  output logic             out_last,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             busy
);

  localparam int DATA_W = 4;

  // Round-half-up of 4*atanh(x/16). The largest entry is 7, so bit 3 is never set.
  function automatic logic [DATA_W-1:0] atanh_lut(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    case (x)
      4'd0:    y = 4'd0;
      4'd1:    y = 4'd0;
      4'd2:    y = 4'd1;
      4'd3:    y = 4'd1;
      4'd4:    y = 4'd1;
      4'd5:    y = 4'd1;
      4'd6:    y = 4'd2;
      4'd7:    y = 4'd2;
      4'd8:    y = 4'd2;
      4'd9:    y = 4'd3;
      4'd10:   y = 4'd3;
      4'd11:   y = 4'd3;
      4'd12:   y = 4'd4;
      4'd13:   y = 4'd5;
      4'd14:   y = 4'd5;
      default: y = 4'd7;
    endcase
    return y;
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;
  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;
  logic              last_p2;

  logic s2_can_load;
  logic adv_p1;
  logic in_fire;
  logic out_fire;

  assign s2_can_load = !vld_p2 | out_ready;
  assign adv_p1      = vld_p1 & s2_can_load;
  assign in_ready    = !vld_p1 | s2_can_load;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = vld_p2 & out_ready;

  assign out_valid = vld_p2;
  assign Out1      = data_p2;
  assign out_last  = last_p2;
  assign busy      = vld_p1 | vld_p2;

  // ---- stage 1: capture input code and frame flag ----
  // Stage-1 occupancy: fills on input handshake, empties when advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_fire | (vld_p1 & !adv_p1);
    end
  end

  // Stage-1 payload needs no reset; its valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_p1 <= In;
      last_p1 <= in_last;
    end
  end

  // ---- stage 2: registered lookup result drives the output port ----
  // Stage-2 occupancy and payload. The payload is cleared by reset so Out1 reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      last_p2 <= 1'b0;
    end else begin
      vld_p2 <= adv_p1 | (vld_p2 & !out_ready);
      if (adv_p1) begin
        data_p2 <= atanh_lut(data_p1);
        last_p2 <= last_p1;
      end
    end
  end

  // Handshake counters. Both can step on the same edge and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      frame_cnt  <= '0;
    end else if (out_fire) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (last_p2) frame_cnt <= frame_cnt + FRM_W'(1);
    end
  end

endmodule

// File: tb/tb_atanh_approx_4bit_stream.sv
// Testbench for atanh_approx_4bit_stream.
// It uses a lookup vector table, an in-order scoreboard with latency tracking,
// and hand-written sequences for reset, stall, wrap and gap behaviour.
module tb_atanh_approx_4bit_stream;

  typedef struct {
    logic [3:0] in;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  In;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  Out1;
  logic        out_last;
  logic [15:0] sample_cnt;
  logic [7:0]  frame_cnt;
  logic        busy;

  vec_t tab[16];
  exp_t sb[$];
  int   tq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   timing_chk = 0;
  bit   rand_mode = 0;

  atanh_approx_4bit_stream #(.CNT_W(16), .FRM_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .In(In), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .Out1(Out1), .out_last(out_last),
    .sample_cnt(sample_cnt), .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: every output handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got Out1=%0d with no sample pending, expected none", Out1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out1", {28'd0, Out1}, {28'd0, e.out});
        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
      end
      if (timing_chk) begin
        if (tq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_cycle: got output at cycle %0d, expected none", cyc);
        end else begin
          chk("out_cycle", cyc, tq.pop_front());
        end
      end
    end
  end

  // Random backpressure generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [3:0] x, input logic l);
    int  n;
    bit  got;
    exp_t e;
    in_valid = 1'b1;
    In       = x;
    in_last  = l;
    got      = 0;
    n        = 0;
    while (!got) begin
      @(negedge clk);
      if (in_ready) begin
        got   = 1;
        e.out  = tab[int'(x)].exp;
        e.last = l;
        sb.push_back(e);
        if (timing_chk) tq.push_back(cyc + 2);
      end
      @(posedge clk);
      #1;
      n++;
      if (!got && n > 1000) begin
        n_fail++;
        $display("FAIL send_timeout: got no in_ready in %0d cycles, expected handshake", n);
        $fatal(1, "input handshake timeout");
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    sb.delete();
    tq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    tab[0]  = '{4'd0,  4'd0}; tab[1]  = '{4'd1,  4'd0};
    tab[2]  = '{4'd2,  4'd1}; tab[3]  = '{4'd3,  4'd1};
    tab[4]  = '{4'd4,  4'd1}; tab[5]  = '{4'd5,  4'd1};
    tab[6]  = '{4'd6,  4'd2}; tab[7]  = '{4'd7,  4'd2};
    tab[8]  = '{4'd8,  4'd2}; tab[9]  = '{4'd9,  4'd3};
    tab[10] = '{4'd10, 4'd3}; tab[11] = '{4'd11, 4'd3};
    tab[12] = '{4'd12, 4'd4}; tab[13] = '{4'd13, 4'd5};
    tab[14] = '{4'd14, 4'd5}; tab[15] = '{4'd15, 4'd7};

    rst_n = 1'b0; in_valid = 1'b0; In = 4'd0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out1", {28'd0, Out1}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_sample_cnt", {16'd0, sample_cnt}, 0);
    chk("rst_frame_cnt", {24'd0, frame_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);

    // Sweep of the whole table, back to back, with latency and rate tracking
    out_ready  = 1'b1;
    timing_chk = 1;
    for (int i = 0; i < 16; i++) send(tab[i].in, (i == 15));
    drain();
    timing_chk = 0;
    chk("sweep_sample_cnt", {16'd0, sample_cnt}, 16);
    chk("sweep_frame_cnt", {24'd0, frame_cnt}, 1);

    // Backpressure: 15 and 13 fill both stages, 9 is refused while stalled
    out_ready = 1'b0;
    send(4'd15, 1'b0);
    send(4'd13, 1'b0);
    in_valid = 1'b1; In = 4'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      chk("hold_out_valid", {31'd0, out_valid}, 1);
      chk("hold_out1", {28'd0, Out1}, 7);
      chk("hold_out_last", {31'd0, out_last}, 0);
      chk("hold_busy", {31'd0, busy}, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'd9, 1'b1);
    drain();
    chk("hold_sample_cnt", {16'd0, sample_cnt}, 19);
    chk("hold_frame_cnt", {24'd0, frame_cnt}, 2);

    // Source gaps: one idle cycle between samples must not add output bubbles
    timing_chk = 1;
    for (int i = 0; i < 12; i++) begin
      send(4'(15 - i), i[0]);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    drain();
    timing_chk = 0;
    chk("gap_sample_cnt", {16'd0, sample_cnt}, 31);
    chk("gap_frame_cnt", {24'd0, frame_cnt}, 8);

    // Reset while two samples are held in the pipeline
    out_ready = 1'b0;
    send(4'd3, 1'b0);
    send(4'd12, 1'b1);
    in_valid = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_sample_cnt", {16'd0, sample_cnt}, 0);
    chk("mid_rst_frame_cnt", {24'd0, frame_cnt}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    sb.delete();
    tq.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'd0, out_valid}, 0);
      chk("post_rst_ready", {31'd0, in_ready}, 1);
    end
    @(posedge clk);
    #1;

    // Random backpressure over 1000 random samples, frame every 8th
    rand_mode = 1;
    for (int i = 0; i < 1000; i++) send(4'($urandom_range(0, 15)), (i % 8) == 7);
    rand_mode = 0;
    out_ready = 1'b1;
    drain();
    chk("rand_sample_cnt", {16'd0, sample_cnt}, 1000);
    chk("rand_frame_cnt", {24'd0, frame_cnt}, 125);

    // Counter wrap: 65535 transfers, then a last-flagged one wraps sample_cnt
    reset_pulse();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send(4'(i), 1'b0);
    drain();
    chk("wrap_pre_sample_cnt", {16'd0, sample_cnt}, 32'h0000_FFFF);
    chk("wrap_pre_frame_cnt", {24'd0, frame_cnt}, 0);
    send(4'd15, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!(out_valid && out_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_out_seen", {31'd0, (out_valid && out_ready)}, 1);
    @(posedge clk);
    #1;
    chk("wrap_sample_cnt", {16'd0, sample_cnt}, 0);
    chk("wrap_frame_cnt", {24'd0, frame_cnt}, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atanh_approx_4bit_stream.md
Name: atanh_approx_4bit_stream

Overview:
- Streaming inverse-activation block: takes 4-bit unsigned tanh-domain codes and returns the inverse hyperbolic tangent, atanh, as 4-bit codes.
- Used downstream of the approximate tanh circuits to recover pre-activation magnitudes for calibration and error characterisation.
- Input and output are valid/ready streams with frame delimiting.
- The block also maintains sample and frame counters for the characterisation harness.

Parameters:
- CNT_W, 16, width of the sample counter.
- FRM_W, 8, width of the frame counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input code valid.
- in_ready  out  1  block can accept an input this cycle.
- In  in  4  tanh-domain code, unsigned Q0.4; value = In/16, range [0, 0.9375].
- in_last  in  1  marks the last sample of a frame; travels with In.
- out_valid  out  1  output code valid.
- out_ready  in  1  downstream can accept an output this cycle.
- Out1  out  4  atanh result, unsigned Q2.2; value = Out1/4.
- out_last  out  1  in_last delayed with its sample.
- sample_cnt  out  CNT_W  count of completed output handshakes; wraps.
- frame_cnt  out  FRM_W  count of output handshakes with out_last=1; wraps.
- busy  out  1  1 when any pipeline stage holds valid data.

Behaviour:
- Reset: asynchronous assert when rst_n=0. In reset, all stage valid bits, Out1, out_last, sample_cnt, frame_cnt and busy are 0.
- Reset state of in_ready: 1 during reset, and again from the first clk edge after release.
- Deassertion of rst_n takes effect at the next clk edge.
- Reset mid-stream: all in-flight samples are discarded, with no partial output.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer occurs when out_valid & out_ready at a rising edge.
- Pipeline: two-stage elastic pipeline.
  - S1 registers In and in_last.
  - S2 registers the lookup result and last flag. out_valid and Out1 come from S2 registers, never combinationally from In.
- Stage advance rules:
  - S2 loads when it is empty or being drained this cycle.
  - S1 loads when it is empty or advancing into S2.
  - in_ready = !s1_valid | s2_can_load. No data is lost or duplicated under any out_ready pattern.
- Timing:
  - Latency is 2 cycles from input handshake to out_valid, with out_ready held high.
  - Throughput is 1 sample per cycle sustained.
- Holding rule: while out_valid=1 and out_ready=0, Out1 and out_last hold stable.
- Lookup, exact, with round-half-up of 4·atanh(x/16), shown as In -> Out1:
  - 0->0, 1->0, 2->1, 3->1, 4->1, 5->1, 6->2, 7->2
  - 8->2, 9->3, 10->3, 11->3, 12->4, 13->5, 14->5, 15->7
  - Out1[3] is therefore always 0. No saturation path is needed, since the maximum is 7.
- Counters:
  - sample_cnt increments by 1 on each output handshake, wrapping from 2^CNT_W−1 to 0.
  - frame_cnt increments on each output handshake with out_last=1, wrapping the same way.
  - When one handshake qualifies for both, both counters increment in the same cycle.
- busy = s1_valid | s2_valid.
- Simultaneous events: input and output handshakes in the same cycle with both stages full is legal and keeps occupancy at 2.
- No FSM beyond per-stage valid bits. Stage state per cycle is EMPTY/FULL; transitions are exactly as given by the load/drain rules above.

Test Plan:
- Reset with rst_n=0 mid-stream holding 2 samples -> out_valid=0, busy=0, counters 0 immediately; in_ready=1 after release. No stale output appears afterwards.
- Sweep In=0..15 back-to-back, out_ready=1 -> Out1 sequence 0,0,1,1,1,1,2,2,2,3,3,3,4,5,5,7. First out_valid 2 cycles after the first input handshake; one output per cycle; sample_cnt=16.
- Stream In=15,13,9 with out_ready=0 for 5 cycles -> pipeline holds 2 samples with in_ready=0 and Out1=7 stable. After out_ready=1, outputs arrive in order 7,5,3.
- Random out_ready (50%) over 1000 random samples with in_last every 8th -> scoreboard matches the table in order. frame_cnt=125; sample_cnt=1000.
- Preload sample_cnt to 0xFFFF via 65535 transfers, then one more with in_last=1 -> sample_cnt=0 and frame_cnt increments in the same cycle.
- Toggle in_valid every other cycle, out_ready=1 -> no bubbles inserted beyond the source gaps; out_last aligns exactly with its sample.
